zigzag_reorder_buf: RTL and testbench



---
 rtl/zigzag_reorder_buf.sv | 96 +++++++++
 tb/tb_zigzag_reorder_buf.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_reorder_buf.sv
// Ping-pong 8x8 coefficient buffer: accepts raster-order coefficients, emits JPEG zigzag order.
// Build option ZZ_TRANSPOSE_EN swaps row/column on the read address for column-major producers.
module zigzag_reorder_buf #(
  parameter int DWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last
);

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DWIDTH-1:0] mem [2][64];

  logic       wr_bank;
  logic       rd_bank;
  logic [5:0] wr_cnt;
  logic [5:0] rd_cnt;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_en;
  logic       wr_done;
  logic       load;
  logic       rd_done;
  logic [5:0] zz_addr;
  logic [5:0] rd_addr;

  assign din_ready = !full[wr_bank];
  assign wr_en     = din_valid && din_ready;
  assign wr_done   = wr_en && (wr_cnt == 6'd63);
  assign load      = full[rd_bank] && (!dout_valid || dout_ready);
  assign rd_done   = load && (rd_cnt == 6'd63);
  assign zz_addr   = ZZ[rd_cnt];

`ifdef ZZ_TRANSPOSE_EN
  assign rd_addr = {zz_addr[2:0], zz_addr[5:3]};
`else
  assign rd_addr = zz_addr;
`endif

  // Fill and release always target different banks, so both updates can apply on one edge.
  always_comb begin
    full_nxt = full;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_cnt] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      full       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (load) begin
        dout       <= mem[rd_bank][rd_addr];
        dout_valid <= 1'b1;
        dout_last  <= (rd_cnt == 6'd63);
        rd_cnt     <= rd_cnt + 6'd1;
        if (rd_done) rd_bank <= ~rd_bank;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zigzag_reorder_buf.sv
// Self-checking bench for zigzag_reorder_buf: zigzag model built from diagonal traversal plus a scoreboard.
module tb_zigzag_reorder_buf;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_last;

  always #5 clk = ~clk;

  zigzag_reorder_buf #(.DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last)
  );

  typedef struct { logic [DW-1:0] d; logic last; } exp_t;

  int unsigned   n_chk = 0;
  int unsigned   n_fail = 0;
  int            zz_ref [64];
  exp_t          exp_q [$];
  logic [DW-1:0] blk [64];
  int            blk_n = 0;
  int            rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
  bit            chk_rdy = 1'b0;
  int            cyc = 0;
  int            n_wr = 0;
  int            n_pop = 0;
  int            first_pop_cyc = 0;
  int            last_pop_cyc = 0;
  logic [DW-1:0] cap_d [$];
  logic          cap_l [$];
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_d;
  logic          stall_l;
  int            lit [10];

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Zigzag = walk anti-diagonals, alternating direction.
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  function automatic int model_idx(input int k);
`ifdef ZZ_TRANSPOSE_EN
    return (zz_ref[k] % 8) * 8 + zz_ref[k] / 8;
`else
    return zz_ref[k];
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_valid", dout_valid, 1);
        check("stall_data", dout, stall_d);
        check("stall_last", dout_last, stall_l);
      end
      stall_prev = dout_valid && !dout_ready;
      stall_d    = dout;
      stall_l    = dout_last;
      if (chk_rdy && din_valid) check("din_ready_no_bubble", din_ready, 1);
      if (din_valid && din_ready) begin
        blk[blk_n] = din;
        blk_n++;
        n_wr++;
        if (blk_n == 64) begin
          for (int k = 0; k < 64; k++) begin
            e.d = blk[model_idx(k)];
            e.last = (k == 63);
            exp_q.push_back(e);
          end
          blk_n = 0;
        end
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) check("unexpected_output_count", n_pop + 1, n_pop);
        else begin
          e = exp_q.pop_front();
          check("dout", dout, e.d);
          check("dout_last", dout_last, e.last);
        end
        cap_d.push_back(dout);
        cap_l.push_back(dout_last);
        if (n_pop == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        n_pop++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       dout_ready = 1'b0;
        1:       dout_ready = 1'b1;
        default: dout_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int base, input int n, input bit rnd);
    bit acc;
    int w;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        while ($urandom_range(1, 0) == 0) begin din_valid = 1'b0; tick(); end
      end
      din = DW'(base + i);
      din_valid = 1'b1;
      w = 0;
      do begin
        acc = din_ready;
        tick();
        w++;
        if (!acc && w > 3000) begin
          check("write_timeout_cycles", w, 0);
          din_valid = 1'b0;
          return;
        end
      end while (!acc);
    end
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || dout_valid) && w < 3000) begin tick(); w++; end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_last", dout_last, 0);
    check("rst_din_ready", din_ready, 1);
    exp_q.delete();
    blk_n = 0;
    stall_prev = 1'b0;
    din_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_first_block(input string tag);
    check({tag, "_count"}, cap_d.size(), 64);
    if (cap_d.size() == 64) begin
      int nl = 0;
      for (int k = 0; k < 10; k++) check({tag, "_dout_literal"}, cap_d[k], lit[k]);
      check({tag, "_dout_63"}, cap_d[63], 63);
      for (int k = 0; k < 64; k++) nl += cap_l[k];
      check({tag, "_last_count"}, nl, 1);
      check({tag, "_last_pos"}, cap_l[63], 1);
    end
  endtask

  initial begin
    int wr0;
`ifdef ZZ_TRANSPOSE_EN
    lit = '{0, 8, 1, 2, 9, 16, 24, 17, 10, 3};
`else
    lit = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
`endif
    build_zz();
    for (int k = 0; k < 10; k++) check("model_pin", model_idx(k), lit[k]);
    check("model_pin_63", model_idx(63), 63);

    // Reset state, then one raster-indexed block.
    repeat (3) tick();
    check("reset_dout_valid", dout_valid, 0);
    check("reset_dout", dout, 0);
    check("reset_dout_last", dout_last, 0);
    check("reset_din_ready", din_ready, 1);
    rst_n = 1'b1;
    tick();
    cap_d.delete(); cap_l.delete();
    write_words(0, 64, 1'b0);
    check("latency_not_yet_valid", dout_valid, 0);
    tick();
    check("latency_valid", dout_valid, 1);
    check("latency_first_dout", dout, lit[0]);
    drain();
    check_first_block("t1");

    // Four back-to-back blocks: no din_ready bubble, contiguous output.
    n_pop = 0;
    chk_rdy = 1'b1;
    for (int b = 0; b < 4; b++) write_words(64 * b, 64, 1'b0);
    chk_rdy = 1'b0;
    drain();
    check("b2b_outputs", n_pop, 256);
    check("b2b_contiguous_span", last_pop_cyc - first_pop_cyc, 255);

    // Backpressure: output held 130 cycles while three blocks are offered.
    n_pop = 0;
    wr0 = n_wr;
    rdy_mode = 0;
    tick();
    fork
      begin
        for (int b = 0; b < 3; b++) write_words(64 * b, 64, 1'b0);
      end
    join_none
    repeat (130) tick();
    check("bp_writes_accepted", n_wr - wr0, 128);
    check("bp_din_ready_low", din_ready, 0);
    check("bp_dout_valid", dout_valid, 1);
    check("bp_dout_value", dout, 0);
    rdy_mode = 1;
    wait fork;
    drain();
    check("bp_outputs", n_pop, 192);

    // Random valid and ready over ten blocks.
    n_pop = 0;
    rdy_mode = 2;
    for (int b = 0; b < 10; b++) write_words(64 * b + 1000, 64, 1'b1);
    rdy_mode = 1;
    drain();
    check("rand_outputs", n_pop, 640);

    // Reset while block 1 is partly written and block 0 is partly drained.
    rdy_mode = 0;
    tick();
    write_words(3000, 64, 1'b0);
    write_words(3064, 20, 1'b0);
    rdy_mode = 1;
    write_words(3084, 20, 1'b0);
    do_reset();
    n_pop = 0;
    cap_d.delete(); cap_l.delete();
    write_words(0, 64, 1'b0);
    drain();
    check_first_block("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
